interleave: RTL and testbench

INTERLEAVE -- requirements
Module: interleave

---
 rtl/ofdm_tx_pkg.sv | 92 +++++++++
 rtl/interleave_addr_gen.sv | 59 +++++
 rtl/interleave.sv | 196 +++++++++++++++++++
 tb/tb_interleave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_tx_pkg.sv
// rtl/ofdm_tx_pkg.sv - shared OFDM TX rate codes, N_BPSC decode and interleaver geometry
// HT (802.11n MCS 0-7) support is compiled in only with INTERLEAVE_HT_EN defined.
package ofdm_tx_pkg;

    localparam logic [7:0] RATE_6M  = 8'h0B;
    localparam logic [7:0] RATE_9M  = 8'h0F;
    localparam logic [7:0] RATE_12M = 8'h0A;
    localparam logic [7:0] RATE_18M = 8'h0E;
    localparam logic [7:0] RATE_24M = 8'h09;
    localparam logic [7:0] RATE_36M = 8'h0D;
    localparam logic [7:0] RATE_48M = 8'h08;
    localparam logic [7:0] RATE_54M = 8'h0C;

`ifdef INTERLEAVE_HT_EN
    localparam logic [7:0] HT_MCS0 = 8'h80;
    localparam logic [7:0] HT_MCS1 = 8'h81;
    localparam logic [7:0] HT_MCS2 = 8'h82;
    localparam logic [7:0] HT_MCS3 = 8'h83;
    localparam logic [7:0] HT_MCS4 = 8'h84;
    localparam logic [7:0] HT_MCS5 = 8'h85;
    localparam logic [7:0] HT_MCS6 = 8'h86;
    localparam logic [7:0] HT_MCS7 = 8'h87;
    localparam int BANK_BITS = 312;
`else
    localparam int BANK_BITS = 288;
`endif

    localparam int N_SD_LEGACY  = 48;
    localparam int N_COL_LEGACY = 16;
    localparam int N_SD_HT      = 52;
    localparam int N_COL_HT     = 13;
    localparam int ADDR_W       = 9;

    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic {R_IDLE, R_OUT} r_state_t;

    typedef struct packed {
        logic       ht;
        logic [2:0] nbpsc;
    } rate_cfg_t;

    // Returns 0 for any unsupported code.
    function automatic logic [2:0] nbpsc_decode(input logic [7:0] rate);
        logic [2:0] n;
        n = 3'd0;
        case (rate)
            RATE_6M,  RATE_9M:  n = 3'd1;
            RATE_12M, RATE_18M: n = 3'd2;
            RATE_24M, RATE_36M: n = 3'd4;
            RATE_48M, RATE_54M: n = 3'd6;
`ifdef INTERLEAVE_HT_EN
            HT_MCS0:                   n = 3'd1;
            HT_MCS1, HT_MCS2:          n = 3'd2;
            HT_MCS3, HT_MCS4:          n = 3'd4;
            HT_MCS5, HT_MCS6, HT_MCS7: n = 3'd6;
`endif
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [4:0] cfg_n_col(input rate_cfg_t cfg);
        return cfg.ht ? 5'(N_COL_HT) : 5'(N_COL_LEGACY);
    endfunction

    function automatic logic [5:0] cfg_n_sd(input rate_cfg_t cfg);
        return cfg.ht ? 6'(N_SD_HT) : 6'(N_SD_LEGACY);
    endfunction

    // N_ROW = N_SD*N_BPSC/N_COL, i.e. 3*N_BPSC legacy, 4*N_BPSC HT.
    function automatic logic [4:0] cfg_n_row(input rate_cfg_t cfg);
        logic [4:0] r;
        case (cfg.nbpsc)
            3'd2:    r = cfg.ht ? 5'd8  : 5'd6;
            3'd4:    r = cfg.ht ? 5'd16 : 5'd12;
            3'd6:    r = cfg.ht ? 5'd24 : 5'd18;
            default: r = cfg.ht ? 5'd4  : 5'd3;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] cfg_s(input rate_cfg_t cfg);
        logic [1:0] s;
        case (cfg.nbpsc)
            3'd4:    s = 2'd2;
            3'd6:    s = 2'd3;
            default: s = 2'd1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/interleave_addr_gen.sv
// rtl/interleave_addr_gen.sv - divider-free write address j for write index k
// Tracks col=k mod N_COL, row=k div N_COL, N_ROW*col, row mod s and (row-col) mod s incrementally.
module interleave_addr_gen
    import ofdm_tx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              step,
    input  logic [4:0]        n_col,
    input  logic [4:0]        n_row,
    input  logic [1:0]        s,
    output logic [ADDR_W-1:0] j,
    output logic              last
);

    logic [4:0]        col;
    logic [4:0]        row;
    logic [ADDR_W-1:0] i_col;
    logic [1:0]        r_mod;
    logic [1:0]        d;
    logic [1:0]        r_mod_inc;
    logic              col_wrap;

    assign col_wrap  = (col == n_col - 5'd1);
    assign last      = col_wrap && (row == n_row - 5'd1);
    assign r_mod_inc = (r_mod == s - 2'd1) ? 2'd0 : r_mod + 2'd1;
    // j = i - (row mod s) + ((row - col) mod s), with i = N_ROW*col + row
    assign j = i_col + ADDR_W'(row) - ADDR_W'(r_mod) + ADDR_W'(d);

    always_ff @(posedge clock) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            i_col <= '0;
            r_mod <= '0;
            d     <= '0;
        end else if (step) begin
            if (last) begin
                col   <= '0;
                row   <= '0;
                i_col <= '0;
                r_mod <= '0;
                d     <= '0;
            end else if (col_wrap) begin
                // col returns to 0, so (row-col) mod s equals the new row mod s
                col   <= '0;
                row   <= row + 5'd1;
                i_col <= '0;
                r_mod <= r_mod_inc;
                d     <= r_mod_inc;
            end else begin
                col   <= col + 5'd1;
                i_col <= i_col + ADDR_W'(n_row);
                d     <= (d == 2'd0) ? s - 2'd1 : d - 2'd1;
            end
        end
    end

endmodule

// File: rtl/interleave.sv
// rtl/interleave.sv - ping-pong OFDM bit interleaver, one subcarrier per output beat
// HT rates are accepted only when INTERLEAVE_HT_EN is defined; otherwise they raise rate_err.
module interleave
    import ofdm_tx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] rate,
    input  logic       in_bit,
    input  logic       input_strobe,
    output logic       input_ready,
    output logic [5:0] out_bits,
    output logic       output_strobe,
    input  logic       output_ready,
    output logic       rate_err
);

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic              wr_bank;
    logic [1:0]        full;
    rate_cfg_t         cfg_in, cfg_lat, cfg_w;
    rate_cfg_t         bank_cfg [2];
    logic [BANK_BITS-1:0] mem [2];

    logic              accept, rate_ok;
    logic              do_write, w_done, set_err, latch_cfg;
    logic [ADDR_W-1:0] wr_addr;
    logic              addr_last;
    logic [1:0]        w_set, r_clr;

    logic              rd_bank, rd_bank_n;
    logic [5:0]        rd_c, rd_c_n;
    logic [ADDR_W-1:0] rd_base, rd_base_n;
    logic              load, strobe_n, rd_done;
    logic [5:0]        next_bits;
    logic [2:0]        sel_nbpsc;
    logic [ADDR_W-1:0] idx;

    assign cfg_in      = {rate[7], nbpsc_decode(rate)};
    assign rate_ok     = (cfg_in.nbpsc != 3'd0);
    // k=0 is written in the same cycle the rate is latched, so use the live rate then.
    assign cfg_w       = (w_state == W_IDLE) ? cfg_in : cfg_lat;
    assign input_ready = !(&full) && !rate_err;
    assign accept      = input_strobe && input_ready && enable;

    interleave_addr_gen u_addr_gen (
        .clock (clock),
        .reset (reset),
        .step  (do_write),
        .n_col (cfg_n_col(cfg_w)),
        .n_row (cfg_n_row(cfg_w)),
        .s     (cfg_s(cfg_w)),
        .j     (wr_addr),
        .last  (addr_last)
    );

    always_comb begin
        w_next    = w_state;
        do_write  = 1'b0;
        w_done    = 1'b0;
        set_err   = 1'b0;
        latch_cfg = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (accept) begin
                    if (rate_ok) begin
                        do_write  = 1'b1;
                        latch_cfg = 1'b1;
                        w_next    = W_FILL;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (accept) begin
                    do_write = 1'b1;
                    if (addr_last) begin
                        w_done = 1'b1;
                        w_next = W_IDLE;
                    end
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign w_set = w_done  ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign r_clr = rd_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state     <= W_IDLE;
            wr_bank     <= 1'b0;
            cfg_lat     <= '0;
            rate_err    <= 1'b0;
            full        <= 2'b00;
            bank_cfg[0] <= '0;
            bank_cfg[1] <= '0;
        end else if (enable) begin
            w_state <= w_next;
            if (latch_cfg)
                cfg_lat <= cfg_in;
            if (set_err)
                rate_err <= 1'b1;
            if (w_done) begin
                wr_bank           <= ~wr_bank;
                bank_cfg[wr_bank] <= cfg_lat;
            end
            // Set and clear always target opposite banks, so both land together.
            full <= (full | w_set) & ~r_clr;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write)
            mem[wr_bank][wr_addr] <= in_bit;
    end

    always_comb begin
        r_next    = r_state;
        rd_bank_n = rd_bank;
        rd_c_n    = rd_c;
        rd_base_n = rd_base;
        load      = 1'b0;
        strobe_n  = output_strobe;
        rd_done   = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (full[rd_bank]) begin
                    r_next    = R_OUT;
                    rd_c_n    = '0;
                    rd_base_n = '0;
                    load      = 1'b1;
                    strobe_n  = 1'b1;
                end
            end
            R_OUT: begin
                if (output_ready) begin
                    if (rd_c == cfg_n_sd(bank_cfg[rd_bank]) - 6'd1) begin
                        rd_done   = 1'b1;
                        rd_bank_n = ~rd_bank;
                        rd_c_n    = '0;
                        rd_base_n = '0;
                        if (full[~rd_bank]) begin
                            load = 1'b1;
                        end else begin
                            r_next   = R_IDLE;
                            strobe_n = 1'b0;
                        end
                    end else begin
                        rd_c_n    = rd_c + 6'd1;
                        rd_base_n = rd_base + ADDR_W'(bank_cfg[rd_bank].nbpsc);
                        load      = 1'b1;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        next_bits = '0;
        idx       = '0;
        sel_nbpsc = bank_cfg[rd_bank_n].nbpsc;
        for (int b = 0; b < 6; b++) begin
            idx = rd_base_n + ADDR_W'(b);
            if (3'(b) < sel_nbpsc && idx < ADDR_W'(BANK_BITS))
                next_bits[b] = mem[rd_bank_n][idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= R_IDLE;
            rd_bank       <= 1'b0;
            rd_c          <= '0;
            rd_base       <= '0;
            out_bits      <= '0;
            output_strobe <= 1'b0;
        end else if (enable) begin
            r_state       <= r_next;
            rd_bank       <= rd_bank_n;
            rd_c          <= rd_c_n;
            rd_base       <= rd_base_n;
            output_strobe <= strobe_n;
            if (load)
                out_bits <= next_bits;
            else if (!strobe_n)
                out_bits <= '0;
        end
    end

endmodule

// File: tb/tb_interleave.sv
// tb/tb_interleave.sv - directed self-checking bench for interleave
module tb_interleave;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] rate;
    logic       in_bit;
    logic       input_strobe;
    logic       input_ready;
    logic [5:0] out_bits;
    logic       output_strobe;
    logic       output_ready;
    logic       rate_err;

    int compared   = 0;
    int mismatched = 0;
    logic [5:0] cap [$];

    always #5 clock = ~clock;

    interleave dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .rate          (rate),
        .in_bit        (in_bit),
        .input_strobe  (input_strobe),
        .input_ready   (input_ready),
        .out_bits      (out_bits),
        .output_strobe (output_strobe),
        .output_ready  (output_ready),
        .rate_err      (rate_err)
    );

    always @(negedge clock)
        if (!reset && output_strobe && output_ready)
            cap.push_back(out_bits);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset        = 1'b1;
        input_strobe = 1'b0;
        in_bit       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        cap.delete();
    endtask

    task automatic send_symbol(input logic [7:0] r, input int nbits, input int i1, input int i2);
        int t;
        for (int k = 0; k < nbits; k++) begin
            rate         = r;
            in_bit       = (k == i1) || (k == i2);
            input_strobe = 1'b1;
            t = 0;
            while (!input_ready && t < 600) begin
                @(posedge clock);
                #1;
                t++;
            end
            if (!input_ready) begin
                compared++;
                mismatched++;
                $display("FAIL send_timeout rate=%h k=%0d: input_ready=%b required 1", r, k, input_ready);
                input_strobe = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        input_strobe = 1'b0;
        in_bit       = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input int budget);
        int t = 0;
        while (cap.size() < n && t < budget) begin
            @(posedge clock);
            #1;
            t++;
        end
        compared++;
        if (cap.size() < n) begin
            mismatched++;
            $display("FAIL out_count: got %0d subcarriers, required %0d", cap.size(), n);
        end
    endtask

    task automatic test_reset();
        enable       = 1'b1;
        rate         = 8'h0B;
        output_ready = 1'b1;
        do_reset();
        compared += 4;
        if (output_strobe !== 1'b0) begin mismatched++; $display("FAIL reset_strobe: got %b required 0", output_strobe); end
        if (out_bits !== 6'd0)      begin mismatched++; $display("FAIL reset_bits: got %b required 000000", out_bits); end
        if (rate_err !== 1'b0)      begin mismatched++; $display("FAIL reset_err: got %b required 0", rate_err); end
        if (input_ready !== 1'b1)   begin mismatched++; $display("FAIL reset_ready: got %b required 1", input_ready); end
    endtask

    task automatic test_patterns();
        logic [7:0] rate_t [6] = '{8'h0B, 8'h0C, 8'h0C, 8'h0C, 8'h0D, 8'h0D};
        int         nb_t   [6] = '{48, 288, 288, 288, 192, 192};
        int         idx_t  [6] = '{1, 17, 0, 1, 16, 1};
        int         sc_t   [6] = '{3, 3, 0, 3, 0, 3};
        logic [5:0] val_t  [6] = '{6'b000001, 6'b000001, 6'b000001, 6'b000100, 6'b000010, 6'b000010};
        logic [5:0] exp;
        output_ready = 1'b1;
        do_reset();
        for (int p = 0; p < 6; p++) begin
            cap.delete();
            send_symbol(rate_t[p], nb_t[p], idx_t[p], -1);
            compared++;
            if (output_strobe !== 1'b0) begin
                mismatched++;
                $display("FAIL strobe_early p%0d: got %b required 0", p, output_strobe);
            end
            @(posedge clock);
            #1;
            compared++;
            if (output_strobe !== 1'b1) begin
                mismatched++;
                $display("FAIL strobe_latency p%0d: got %b required 1", p, output_strobe);
            end
            wait_outputs(48, 200);
            for (int c = 0; c < 48 && c < cap.size(); c++) begin
                exp = (c == sc_t[p]) ? val_t[p] : 6'd0;
                compared++;
                if (cap[c] !== exp) begin
                    mismatched++;
                    $display("FAIL pattern p%0d sc%0d: got %b required %b", p, c, cap[c], exp);
                end
            end
        end
    endtask

    task automatic test_ht();
        do_reset();
        output_ready = 1'b1;
`ifdef INTERLEAVE_HT_EN
        send_symbol(8'h87, 312, 14, -1);
        wait_outputs(52, 200);
        for (int c = 0; c < 52 && c < cap.size(); c++) begin
            compared++;
            if (cap[c] !== ((c == 4) ? 6'b000001 : 6'd0)) begin
                mismatched++;
                $display("FAIL ht_mcs7 sc%0d: got %b required %b", c, cap[c], (c == 4) ? 6'b000001 : 6'd0);
            end
        end
`else
        send_symbol(8'h87, 1, 0, -1);
        compared += 2;
        if (rate_err !== 1'b1)    begin mismatched++; $display("FAIL ht_disabled_err: got %b required 1", rate_err); end
        if (input_ready !== 1'b0) begin mismatched++; $display("FAIL ht_disabled_ready: got %b required 0", input_ready); end
        do_reset();
`endif
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp [144];
        do_reset();
        output_ready = 1'b0;
        for (int c = 0; c < 144; c++) exp[c] = 6'd0;
        exp[0]  = 6'b000001;
        exp[3]  = 6'b000001;
        exp[54] = 6'b000001;
        exp[96] = 6'b000001;
        fork
            begin
                send_symbol(8'h0B, 48, 0, 1);
                send_symbol(8'h0B, 48, 2, -1);
                compared++;
                if (input_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL bp_ready_drop: got %b required 0", input_ready);
                end
                send_symbol(8'h0B, 48, 0, -1);
            end
            begin
                repeat (100) @(posedge clock);
                #1;
                compared += 2;
                if (output_strobe !== 1'b1) begin mismatched++; $display("FAIL bp_hold_strobe: got %b required 1", output_strobe); end
                if (out_bits !== 6'b000001) begin mismatched++; $display("FAIL bp_hold_bits: got %b required 000001", out_bits); end
                output_ready = 1'b1;
            end
        join
        wait_outputs(144, 400);
        for (int c = 0; c < 144 && c < cap.size(); c++) begin
            compared++;
            if (cap[c] !== exp[c]) begin
                mismatched++;
                $display("FAIL bp_data sc%0d: got %b required %b", c, cap[c], exp[c]);
            end
        end
    endtask

    task automatic test_rate_err();
        logic saw;
        do_reset();
        output_ready = 1'b1;
        send_symbol(8'h05, 1, 0, -1);
        compared += 2;
        if (rate_err !== 1'b1)    begin mismatched++; $display("FAIL err_set: got %b required 1", rate_err); end
        if (input_ready !== 1'b0) begin mismatched++; $display("FAIL err_ready: got %b required 0", input_ready); end
        saw = 1'b0;
        rate = 8'h0B;
        input_strobe = 1'b1;
        repeat (60) begin
            @(posedge clock);
            #1;
            if (output_strobe) saw = 1'b1;
        end
        input_strobe = 1'b0;
        compared += 2;
        if (saw !== 1'b0)      begin mismatched++; $display("FAIL err_no_output: got %b required 0", saw); end
        if (rate_err !== 1'b1) begin mismatched++; $display("FAIL err_sticky: got %b required 1", rate_err); end
        do_reset();
        compared += 2;
        if (rate_err !== 1'b0)    begin mismatched++; $display("FAIL err_clear: got %b required 0", rate_err); end
        if (input_ready !== 1'b1) begin mismatched++; $display("FAIL err_ready_back: got %b required 1", input_ready); end
    endtask

    task automatic test_reset_mid_read();
        int t = 0;
        do_reset();
        output_ready = 1'b1;
        send_symbol(8'h0B, 48, 1, -1);
        while (cap.size() < 20 && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        compared++;
        if (cap.size() != 20) begin
            mismatched++;
            $display("FAIL mid_read_reach: got %0d subcarriers, required 20", cap.size());
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        compared += 2;
        if (output_strobe !== 1'b0) begin mismatched++; $display("FAIL mid_reset_strobe: got %b required 0", output_strobe); end
        if (out_bits !== 6'd0)      begin mismatched++; $display("FAIL mid_reset_bits: got %b required 000000", out_bits); end
        reset = 1'b0;
        cap.delete();
        send_symbol(8'h0C, 288, 17, -1);
        wait_outputs(48, 200);
        repeat (5) @(posedge clock);
        #1;
        compared++;
        if (cap.size() != 48) begin
            mismatched++;
            $display("FAIL mid_after_count: got %0d required 48", cap.size());
        end
        for (int c = 0; c < 48 && c < cap.size(); c++) begin
            compared++;
            if (cap[c] !== ((c == 3) ? 6'b000001 : 6'd0)) begin
                mismatched++;
                $display("FAIL mid_after sc%0d: got %b required %b", c, cap[c], (c == 3) ? 6'b000001 : 6'd0);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        rate         = 8'h0B;
        in_bit       = 1'b0;
        input_strobe = 1'b0;
        output_ready = 1'b1;
        test_reset();
        test_patterns();
        test_ht();
        test_back_to_back();
        test_rate_err();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
